seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial pattern transmitter; the driving end of the serial pattern detector interface.
- Accepts a SEQ_WIDTH-bit pattern, a repeat count and an inter-bit gap through a valid/ready handshake.
- Emits the pattern MSB-first as a dout/dout_vld bit stream, matching the detector's din/din_vld input.
- Used as stimulus source and in loopback self-test of the detector.

Parameters:
SEQ_WIDTH, 6, pattern length in bits
CNT_WIDTH, 4, width of repeat-count field
GAP_WIDTH, 3, width of inter-bit idle-cycle field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
start_vld  input  1  request valid
start_rdy  output  1  block can accept request
pat  input  SEQ_WIDTH  pattern, sampled on handshake
rep  input  CNT_WIDTH  repetitions minus one, sampled on handshake
gap  input  GAP_WIDTH  idle cycles after each bit, sampled on handshake
abort  input  1  terminate current transfer
dout  output  1  serial data, to detector din
dout_vld  output  1  serial data valid, to detector din_vld
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: dout=0, dout_vld=0, busy=0, done=0, state=IDLE, start_rdy=1. All outputs are registered or decoded from the state register only.
- FSM states:
  - IDLE: start_rdy=1, busy=0.
  - SEND: dout_vld=1, busy=1.
  - GAP: dout_vld=0, busy=1.
  - DONE: done=1, busy=0, start_rdy=0.
- Handshake:
  - A request is accepted when start_vld && start_rdy at edge T.
  - pat, rep and gap are latched into a shift register and counters at T.
  - start_vld while not in IDLE is ignored; there is no queueing.
- Bit stream:
  - Total bits N = SEQ_WIDTH*(rep+1). rep=0 sends the pattern once; rep=2^CNT_WIDTH-1 sends it 2^CNT_WIDTH times.
  - Bit k (k=0..N-1) is driven at cycle T+1+k*(gap+1), with dout_vld=1 for exactly one cycle.
  - Bit order is MSB first. The pattern reloads from the latched copy at each repetition boundary, so wrap-around is seamless: there is no extra cycle between repetitions beyond the normal gap.
- Gaps:
  - gap=g inserts g cycles with dout_vld=0 after every bit except the last.
  - gap=0 gives back-to-back valid bits and GAP is never entered.
  - dout holds the last driven bit during gap cycles.
- Completion:
  - The cycle after the last bit, state=DONE and done=1 for one cycle.
  - The state then returns to IDLE. Earliest next acceptance is the cycle after done.
  - Latency from handshake to done = 1 + (N-1)*(gap+1) + 1 cycles.
- abort:
  - Sampled in SEND, GAP or DONE; next state is IDLE.
  - dout_vld=0 and busy=0 next cycle; no done pulse.
  - abort in IDLE has no effect.
  - abort and start_vld together in IDLE: the request is accepted.
- rst has priority over everything. rst mid-transfer returns all outputs to reset values on the next edge, with no done pulse.
- Width rules:
  - Bit counter is ceil(log2(SEQ_WIDTH)) bits and wraps at SEQ_WIDTH-1.
  - Repeat counter is CNT_WIDTH bits and counts down to 0.
  - Gap counter is GAP_WIDTH bits and counts down to 0.
  - No overflow is possible.

Decomposition:
- Shared package seq_pkg:
  - FSM state encodings (IDLE, SEND, GAP, DONE).
  - SEQ_WIDTH default.
  - Target pattern constants 6'b111000 and 6'b101110, also used by the detector and benches.
- No sub-module; the counters and shift register fit in one module.
- Optional wrapper seq_loopback (generator + detector, rst_n tied to ~rst) for self-test.

Test Plan:
1. pat=6'b111000, rep=0, gap=0, handshake at T: dout_vld=1 for T+1..T+6, dout=1,1,1,0,0,0, done at T+7, start_rdy=1 at T+8. In loopback the detector result pulses exactly once.
2. pat=6'b101110, rep=1, gap=2: 12 valid bits spaced 3 cycles apart (T+1, T+4, ..., T+34), sequence 101110101110, done at T+35. No valid bit is missing at the repetition wrap.
3. rep=4'hF, gap=3'h7, pat=6'b100001: 96 bits, done at T+1+95*8+1=T+762. busy is high throughout, and start_vld pulses mid-transfer are ignored.
4. abort asserted during the 3rd GAP cycle of scenario 2: dout_vld=0 and busy=0 next cycle, no done, start_rdy=1. A new request is accepted immediately afterwards.
5. rst asserted during SEND of scenario 1: all outputs reach reset values on the next edge. After rst is released, a request is accepted normally.
6. start_vld held high continuously with gap=0, rep=0: requests are accepted one cycle after each done (period SEQ_WIDTH+2 = 8 cycles), with no overlap of dout_vld and done.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator/detector pair:
// FSM encodings, default widths and the reference target patterns.
package seq_pkg;

    localparam int unsigned SEQ_WIDTH_DEF = 6;
    localparam int unsigned CNT_WIDTH_DEF = 4;
    localparam int unsigned GAP_WIDTH_DEF = 3;

    localparam logic [SEQ_WIDTH_DEF-1:0] PAT_A = 6'b111000;
    localparam logic [SEQ_WIDTH_DEF-1:0] PAT_B = 6'b101110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, rep+1 times,
// with a programmable number of idle cycles after every bit but the last.
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_vld,
    output logic                 start_rdy,
    input  logic [SEQ_WIDTH-1:0] pat,
    input  logic [CNT_WIDTH-1:0] rep,
    input  logic [GAP_WIDTH-1:0] gap,
    input  logic                 abort,
    output logic                 dout,
    output logic                 dout_vld,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BIT_W = (SEQ_WIDTH > 1) ? $clog2(SEQ_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SEQ_WIDTH - 1);

    state_e               state_q, state_d;
    logic [SEQ_WIDTH-1:0] pat_q, pat_d;
    logic [SEQ_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CNT_WIDTH-1:0] rep_q, rep_d;
    logic [GAP_WIDTH-1:0] gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic                 dout_q, dout_d;

    logic                 last_bit;
    logic                 adv_dout;
    logic [SEQ_WIDTH-1:0] adv_shreg;
    logic [BIT_W-1:0]     adv_bit;
    logic [CNT_WIDTH-1:0] adv_rep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            bit_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
        end
    end

    // Next bit to drive; at a repetition boundary reload from the latched copy.
    always_comb begin
        last_bit = (bit_q == BIT_LAST) && (rep_q == '0);
        if (bit_q == BIT_LAST) begin
            adv_dout  = pat_q[SEQ_WIDTH-1];
            adv_shreg = {pat_q[SEQ_WIDTH-2:0], 1'b0};
            adv_bit   = '0;
            adv_rep   = rep_q - 1'b1;
        end else begin
            adv_dout  = shreg_q[SEQ_WIDTH-1];
            adv_shreg = {shreg_q[SEQ_WIDTH-2:0], 1'b0};
            adv_bit   = bit_q + 1'b1;
            adv_rep   = rep_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        dout_d    = dout_q;

        unique case (state_q)
            IDLE: begin
                if (start_vld) begin
                    state_d   = SEND;
                    pat_d     = pat;
                    dout_d    = pat[SEQ_WIDTH-1];
                    shreg_d   = {pat[SEQ_WIDTH-2:0], 1'b0};
                    bit_d     = '0;
                    rep_d     = rep;
                    gap_len_d = gap;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = DONE;
                end else if (gap_len_q != '0) begin
                    state_d   = GAP;
                    gap_cnt_d = gap_len_q - 1'b1;
                end else begin
                    dout_d  = adv_dout;
                    shreg_d = adv_shreg;
                    bit_d   = adv_bit;
                    rep_d   = adv_rep;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = SEND;
                    dout_d  = adv_dout;
                    shreg_d = adv_shreg;
                    bit_d   = adv_bit;
                    rep_d   = adv_rep;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    assign start_rdy = (state_q == IDLE);
    assign dout_vld  = (state_q == SEND);
    assign busy      = (state_q == SEND) || (state_q == GAP);
    assign done      = (state_q == DONE);
    assign dout      = dout_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen; outputs sampled on the falling edge.
module tb_seq_gen;
    import seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       start_vld;
    logic       start_rdy;
    logic [5:0] pat;
    logic [3:0] rep;
    logic [2:0] gap;
    logic       abort;
    logic       dout;
    logic       dout_vld;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start_vld (start_vld),
        .start_rdy (start_rdy),
        .pat       (pat),
        .rep       (rep),
        .gap       (gap),
        .abort     (abort),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bit k of a repeated stream is pattern bit (5 - k mod 6).
    function automatic logic [95:0] exp_stream(input logic [5:0] p, input int n);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = p[5 - (k % 6)];
        return r;
    endfunction

    // Caller is at a falling edge; the next rising edge is the handshake edge.
    task automatic send_req(input logic [5:0] p, input logic [3:0] r, input logic [2:0] g,
                            output logic rdy_seen);
        pat       = p;
        rep       = r;
        gap       = g;
        start_vld = 1'b1;
        rdy_seen  = start_rdy;
        @(negedge clk);
        start_vld = 1'b0;
    endtask

    // Records the stream from offset 1 (the falling edge right after the handshake).
    task automatic observe(input int max_cyc, input int gapv, input bit poke,
                           output int nvld, output logic [95:0] bits, output int done_off,
                           output int space_err, output int busy_err, output int rdy_after);
        int last;
        nvld = 0; bits = '0; done_off = -1; space_err = 0; busy_err = 0;
        rdy_after = -1; last = 0;
        for (int off = 1; off <= max_cyc; off++) begin
            if (off > 1) @(negedge clk);
            if (dout_vld) begin
                if (nvld < 96) bits[nvld] = dout;
                if ((nvld == 0 && off != 1) || (nvld > 0 && off - last != gapv + 1))
                    space_err++;
                last = off;
                nvld++;
            end
            if (dout_vld && done) space_err++;
            if (done) begin
                done_off  = off;
                if (busy) busy_err++;
                start_vld = 1'b0;
                @(negedge clk);
                rdy_after = int'(start_rdy);
                break;
            end else if (!busy) begin
                busy_err++;
            end
            if (poke) begin
                start_vld = ((off % 37) == 5);
                pat       = 6'b010101;
            end
        end
        start_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_vld = 1'b0; abort = 1'b0; pat = '0; rep = '0; gap = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout, dout_vld, busy, done, start_rdy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00001", {dout, dout_vld, busy, done, start_rdy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic rdy; int n, d, se, be, ra; logic [95:0] b;
        send_req(PAT_A, 4'd0, 3'd0, rdy);
        observe(20, 0, 1'b0, n, b, d, se, be, ra);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", rdy); end
        checks++; if (n !== 6) begin errors++; $display("FAIL single_nbits: got %0d want 6", n); end
        checks++; if (b[5:0] !== 6'b000111) begin errors++; $display("FAIL single_bits: got %b want 000111", b[5:0]); end
        checks++; if (d !== 7) begin errors++; $display("FAIL single_done_off: got %0d want 7", d); end
        checks++; if (se !== 0 || be !== 0) begin errors++; $display("FAIL single_timing: space_err %0d busy_err %0d want 0 0", se, be); end
        checks++; if (ra !== 1) begin errors++; $display("FAIL single_rdy_after: got %0d want 1", ra); end
    endtask

    task automatic test_repeat_gap();
        logic rdy; int n, d, se, be, ra; logic [95:0] b;
        send_req(PAT_B, 4'd1, 3'd2, rdy);
        observe(60, 2, 1'b0, n, b, d, se, be, ra);
        checks++; if (n !== 12) begin errors++; $display("FAIL rep_nbits: got %0d want 12", n); end
        checks++; if (b[11:0] !== 12'b011101_011101) begin errors++; $display("FAIL rep_bits: got %b want 011101011101", b[11:0]); end
        checks++; if (d !== 35) begin errors++; $display("FAIL rep_done_off: got %0d want 35", d); end
        checks++; if (se !== 0 || be !== 0) begin errors++; $display("FAIL rep_timing: space_err %0d busy_err %0d want 0 0", se, be); end
    endtask

    task automatic test_max_len();
        logic rdy; int n, d, se, be, ra; logic [95:0] b, e;
        send_req(6'b100001, 4'hF, 3'h7, rdy);
        observe(800, 7, 1'b1, n, b, d, se, be, ra);
        e = exp_stream(6'b100001, 96);
        checks++; if (n !== 96) begin errors++; $display("FAIL max_nbits: got %0d want 96", n); end
        checks++; if (b !== e) begin errors++; $display("FAIL max_bits: got %h want %h", b, e); end
        checks++; if (d !== 762) begin errors++; $display("FAIL max_done_off: got %0d want 762", d); end
        checks++; if (se !== 0 || be !== 0) begin errors++; $display("FAIL max_timing: space_err %0d busy_err %0d want 0 0", se, be); end
        checks++; if (ra !== 1) begin errors++; $display("FAIL max_rdy_after: got %0d want 1", ra); end
    endtask

    task automatic test_abort();
        logic rdy; int n, d, se, be, ra; logic [95:0] b;
        send_req(PAT_B, 4'd1, 3'd2, rdy);
        repeat (4) @(negedge clk);
        checks++;
        if ({dout_vld, busy} !== 2'b01) begin
            errors++; $display("FAIL abort_pre_gap: got vld/busy %b want 01", {dout_vld, busy});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({dout_vld, busy, done, start_rdy} !== 4'b0001) begin
            errors++; $display("FAIL abort_state: got vld/busy/done/rdy %b want 0001", {dout_vld, busy, done, start_rdy});
        end
        send_req(PAT_A, 4'd0, 3'd0, rdy);
        observe(20, 0, 1'b0, n, b, d, se, be, ra);
        checks++; if (rdy !== 1'b1 || d !== 7 || b[5:0] !== 6'b000111) begin
            errors++; $display("FAIL abort_restart: rdy %b done_off %0d bits %b want 1 7 000111", rdy, d, b[5:0]);
        end
        abort = 1'b1;
        @(negedge clk);
        send_req(PAT_A, 4'd0, 3'd0, rdy);
        abort = 1'b0;
        observe(20, 0, 1'b0, n, b, d, se, be, ra);
        checks++; if (n !== 6 || d !== 7) begin
            errors++; $display("FAIL abort_idle_accept: nbits %0d done_off %0d want 6 7", n, d);
        end
    endtask

    task automatic test_rst_mid();
        logic rdy; int n, d, se, be, ra; logic [95:0] b;
        send_req(PAT_A, 4'd0, 3'd0, rdy);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout, dout_vld, busy, done, start_rdy} !== 5'b00001) begin
            errors++; $display("FAIL rst_mid: got %b want 00001", {dout, dout_vld, busy, done, start_rdy});
        end
        rst = 1'b0;
        send_req(PAT_B, 4'd0, 3'd0, rdy);
        observe(20, 0, 1'b0, n, b, d, se, be, ra);
        checks++; if (rdy !== 1'b1 || d !== 7 || b[5:0] !== 6'b011101) begin
            errors++; $display("FAIL rst_restart: rdy %b done_off %0d bits %b want 1 7 011101", rdy, d, b[5:0]);
        end
    endtask

    task automatic test_back_to_back();
        int starts[$];
        int overlap;
        logic prev;
        overlap = 0; prev = 1'b0;
        pat = PAT_A; rep = 4'd0; gap = 3'd0;
        start_vld = 1'b1;
        for (int off = 1; off <= 33; off++) begin
            @(negedge clk);
            if (dout_vld && !prev) starts.push_back(off);
            if (dout_vld && done) overlap++;
            prev = dout_vld;
        end
        start_vld = 1'b0;
        checks++; if (starts.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", starts.size()); end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] !== 8) begin
                errors++; $display("FAIL b2b_period: got %0d want 8", starts[i] - starts[i-1]);
            end
        end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        @(negedge clk);
        test_repeat_gap();
        @(negedge clk);
        test_max_len();
        @(negedge clk);
        test_abort();
        @(negedge clk);
        test_rst_mid();
        @(negedge clk);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
